// File: rtl/systolic_feed_scheduler.sv
// Block FIFO plus diagonal row skew feeding the 4x4 brightness systolic array.
// Row i of each popped block reaches the array i advancing cycles after row 0.
module systolic_feed_scheduler #(
    parameter int PE_DATA_WIDTH = 16,
    parameter int DEPTH         = 4,
    parameter int NUM_BLOCKS    = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [PE_DATA_WIDTH*DEPTH-1:0]     in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               pe_ready,
    output logic [PE_DATA_WIDTH*DEPTH-1:0]     pe_data_out,
    output logic [DEPTH-1:0]                   pe_valid_out,
    output logic                               busy,
    output logic [$clog2(NUM_BLOCKS+1)-1:0]    blocks_issued,
    output logic                               done
);

    localparam int BW = PE_DATA_WIDTH * DEPTH;
    localparam int CW = $clog2(NUM_BLOCKS + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] BLK_LAST   = CW'(NUM_BLOCKS - 1);
    localparam logic [CW-1:0] BLK_MAX    = CW'(NUM_BLOCKS);
    localparam logic [FW-1:0] FIFO_FULL  = FW'(FIFO_DEPTH);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;

    state_t        state;
    logic [BW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [FW-1:0] fifo_count;
    logic [CW-1:0] accepted;
    logic [DW-1:0] drain_cnt;
    logic          push;
    logic          pop;
    logic [BW-1:0] head;

    assign in_ready = (state == RUN) && (fifo_count != FIFO_FULL) && (accepted < BLK_MAX);
    assign push     = in_valid && in_ready;
    // Pop looks only at the registered count, so a block never bypasses the FIFO.
    assign pop      = (state == RUN) && pe_ready && (fifo_count != '0);
    assign head     = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            blocks_issued <= '0;
            accepted      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            drain_cnt     <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + 1'b1;
                accepted <= accepted + 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + 1'b1;
                blocks_issued <= blocks_issued + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        blocks_issued <= '0;
                        accepted      <= '0;
                        wr_ptr        <= '0;
                        rd_ptr        <= '0;
                        fifo_count    <= '0;
                    end
                end
                RUN: begin
                    // Leaving RUN on the final pop keeps blocks_issued at NUM_BLOCKS.
                    if (pop && (blocks_issued == BLK_LAST)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (pe_ready) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            state <= DONE_ST;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                DONE_ST: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        logic [PE_DATA_WIDTH-1:0] line_data [r+1];
        logic [r:0]               line_valid;

        // Row r is an (r+1)-stage line; bubbles carry zero data when nothing is popped.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= r; s++) begin
                    line_data[s] <= '0;
                end
                line_valid <= '0;
            end else if (pe_ready) begin
                line_data[0]  <= pop ? head[r*PE_DATA_WIDTH +: PE_DATA_WIDTH] : '0;
                line_valid[0] <= pop;
                for (int s = 1; s <= r; s++) begin
                    line_data[s]  <= line_data[s-1];
                    line_valid[s] <= line_valid[s-1];
                end
            end
        end

        assign pe_data_out[r*PE_DATA_WIDTH +: PE_DATA_WIDTH] = line_data[r];
        assign pe_valid_out[r]                               = line_valid[r];
    end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Randomised scoreboard bench for systolic_feed_scheduler.
// Accepted blocks are queued per row; a negedge monitor checks every emitted row word.
module tb_systolic_feed_scheduler;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int NB = 16;
    localparam int FD = 4;
    localparam int BW = W * D;
    localparam int CW = $clog2(NB + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          pe_ready = 1'b0;
    logic [BW-1:0] pe_data_out;
    logic [D-1:0]  pe_valid_out;
    logic          busy;
    logic [CW-1:0] blocks_issued;
    logic          done;

    systolic_feed_scheduler #(
        .PE_DATA_WIDTH(W),
        .DEPTH(D),
        .NUM_BLOCKS(NB),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pe_ready(pe_ready),
        .pe_data_out(pe_data_out),
        .pe_valid_out(pe_valid_out),
        .busy(busy),
        .blocks_issued(blocks_issued),
        .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the edge about to happen will do, and per-frame bookkeeping.
    bit            p_reset = 1'b1;
    bit            p_adv = 1'b0;
    bit            p_push = 1'b0;
    bit            p_start = 1'b0;
    logic [BW-1:0] p_data = '0;
    bit            tb_active = 1'b0;
    int            acc = 0;
    int            emit [D];
    int            edge_no = 0;
    int            done_count = 0;
    logic [W-1:0]  exp_q [D][$];
    int            acc_edge_q [$];
    bit            v0_hist [D];
    bit            frame_v0 [$];
    logic [BW-1:0] prev_data = '0;
    logic [D-1:0]  prev_valid = '0;
    logic [CW-1:0] prev_issued = '0;

    function automatic void check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        bit exp_done;
        int occ;
        int ae;
        exp_done = 1'b0;
        if (p_reset) begin
            tb_active = 1'b0;
            acc = 0;
            acc_edge_q.delete();
            frame_v0.delete();
            for (int i = 0; i < D; i++) begin
                emit[i] = 0;
                exp_q[i].delete();
                v0_hist[i] = 1'b0;
            end
            check_output("reset_valid", 64'(pe_valid_out), 64'd0);
            check_output("reset_data", 64'(pe_data_out), 64'd0);
            check_output("reset_busy", 64'(busy), 64'd0);
            check_output("reset_done", 64'(done), 64'd0);
            check_output("reset_in_ready", 64'(in_ready), 64'd0);
            check_output("reset_issued", 64'(blocks_issued), 64'd0);
        end else begin
            edge_no++;
            if (p_start) begin
                tb_active = 1'b1;
                acc = 0;
                frame_v0.delete();
                for (int i = 0; i < D; i++) emit[i] = 0;
            end
            if (p_push) begin
                for (int i = 0; i < D; i++) exp_q[i].push_back(p_data[i*W +: W]);
                acc_edge_q.push_back(edge_no);
                acc++;
            end
            if (p_adv) begin
                for (int i = 0; i < D; i++) begin
                    if (pe_valid_out[i]) begin
                        if (exp_q[i].size() == 0) begin
                            check_output($sformatf("row%0d_unexpected_word", i), 64'd1, 64'd0);
                        end else begin
                            check_output($sformatf("row%0d_data", i), 64'(pe_data_out[i*W +: W]),
                                         64'(exp_q[i].pop_front()));
                            if (i == 0) begin
                                ae = acc_edge_q.pop_front();
                                check_output("no_bypass", 64'(edge_no > ae), 64'd1);
                                check_output("issued_count", 64'(blocks_issued), 64'(emit[0] + 1));
                            end
                        end
                        emit[i]++;
                    end else begin
                        check_output($sformatf("row%0d_bubble_data", i), 64'(pe_data_out[i*W +: W]), 64'd0);
                    end
                    if (i > 0) begin
                        check_output($sformatf("row%0d_skew_valid", i), 64'(pe_valid_out[i]), 64'(v0_hist[i]));
                    end
                end
                for (int k = D - 1; k > 1; k--) v0_hist[k] = v0_hist[k-1];
                v0_hist[1] = pe_valid_out[0];
                if (tb_active) frame_v0.push_back(pe_valid_out[0]);
                exp_done = tb_active && pe_valid_out[D-1] && (emit[D-1] == NB);
            end else begin
                check_output("stall_hold_data", 64'(pe_data_out), 64'(prev_data));
                check_output("stall_hold_valid", 64'(pe_valid_out), 64'(prev_valid));
                check_output("stall_hold_issued", 64'(blocks_issued), 64'(prev_issued));
            end
            check_output("done", 64'(done), 64'(exp_done));
            check_output("busy", 64'(busy), 64'(tb_active));
            occ = acc - emit[0];
            check_output("in_ready", 64'(in_ready), 64'(tb_active && (occ < FD) && (acc < NB)));
            if (exp_done) begin
                check_output("issued_at_done", 64'(blocks_issued), 64'(NB));
                done_count++;
                tb_active = 1'b0;
            end
        end
        prev_data   = pe_data_out;
        prev_valid  = pe_valid_out;
        prev_issued = blocks_issued;
        p_reset = reset;
        p_adv   = pe_ready && !reset;
        p_push  = in_valid && in_ready && !reset;
        p_start = start && !tb_active && !exp_done && !reset;
        p_data  = in_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Modes: 0 streaming, 1 six-cycle stall, 2 alternating in_valid, 3 random with stray starts.
    task automatic apply_stimulus(input int mode, input int max_cycles);
        int start_done;
        int cyc;
        start_done = done_count;
        start = 1'b1;
        in_valid = 1'b0;
        pe_ready = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (done_count == start_done && cyc < max_cycles) begin
            case (mode)
                0: begin in_valid = 1'b1; pe_ready = 1'b1; end
                1: begin in_valid = 1'b1; pe_ready = !(cyc >= 8 && cyc < 14); end
                2: begin in_valid = (cyc % 2 == 0); pe_ready = 1'b1; end
                default: begin
                    in_valid = ($urandom % 4) != 0;
                    pe_ready = ($urandom % 4) != 0;
                    start    = ($urandom % 8) == 0;
                end
            endcase
            for (int i = 0; i < D; i++) begin
                in_data[i*W +: W] = (mode == 3) ? W'($urandom) : {8'(cyc), 8'(i)};
            end
            tick();
            cyc++;
        end
        if (cyc >= max_cycles) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_timeout mode=%0d actual=no_done expected=done", mode);
        end
        start = 1'b0;
        pe_ready = 1'b1;
        in_valid = (mode == 0);
        repeat (3) tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic reset_mid_frame();
        start = 1'b1;
        pe_ready = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        repeat (6) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic check_gap_pattern();
        int  f;
        bit  ok;
        f = -1;
        for (int k = 0; k < frame_v0.size(); k++) begin
            if (f < 0 && frame_v0[k]) f = k;
        end
        ok = (f >= 0) && (frame_v0.size() >= f + 2 * NB - 1);
        if (ok) begin
            for (int k = 0; k < 2 * NB - 1; k++) begin
                if (frame_v0[f + k] != (k % 2 == 0)) ok = 1'b0;
            end
        end
        check_output("gap_row0_pattern", 64'(ok), 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        apply_stimulus(0, 500);
        reset_mid_frame();
        apply_stimulus(0, 500);
        apply_stimulus(1, 500);
        apply_stimulus(2, 500);
        check_gap_pattern();
        for (int r = 0; r < 4; r++) apply_stimulus(3, 2000);
        check_output("frames_completed", 64'(done_count), 64'd8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
